axis_packetizer: RTL and testbench
==================================

Name: axis_packetizer

Overview:
- Downstream consumer of the 32-bit AXI4-Stream demux outputs; one instance per demux output (m0/m1).
- Buffers the untimed sample stream in a small FIFO and frames it into fixed-length packets by generating m_tlast every packet_len beats.
- The framed output feeds the DMA S2MM port.
- Absorbs DMA back-pressure and handles clean stop/start on enable.

Parameters:
- DATA_WIDTH, 32, tdata width in bits.
- FIFO_DEPTH, 16, buffer depth in beats. Must be a power of 2 and at least 2.
- LEN_WIDTH, 16, width of packet_len and of the beat counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  1 = accept input beats; 0 = stop accepting, drain buffered data.
- packet_len  in  LEN_WIDTH  beats per packet. Value 0 is treated as 1.
- s_tvalid  in  1  input stream valid.
- s_tready  out  1  input stream ready.
- s_tdata  in  DATA_WIDTH  input stream data.
- m_tvalid  out  1  output stream valid.
- m_tready  in  1  output stream ready.
- m_tdata  out  DATA_WIDTH  output stream data.
- m_tlast  out  1  last beat of packet.
- busy  out  1  packet in progress or FIFO not empty.

Behaviour:
- Reset (resetn=0 at a clk edge): FIFO emptied, beat counter cnt=0, state=IDLE, len_reg=1. Outputs s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0.
- FIFO:
  - Synchronous, first-word-fall-through, registered head; occupancy counter runs 0..FIFO_DEPTH.
  - s_tready = enable & (occupancy != FIFO_DEPTH). Registered full flag; no combinational path from m_tready to s_tready.
  - Latency: input handshake at edge N gives m_tvalid=1 with that data after edge N, i.e. 1 cycle.
  - Simultaneous push and pop: occupancy unchanged. A push while full is impossible, since s_tready=0.
  - m_tdata holds stable while m_tvalid=1 and m_tready=0 (AXIS rule).
- Beat counter (output side):
  - While cnt==0, len_reg <= (packet_len==0) ? 1 : packet_len every cycle. packet_len sampled while cnt!=0 is ignored.
  - m_tlast = m_tvalid & (cnt == len_reg-1).
  - On each output handshake: if m_tlast then cnt<=0, else cnt<=cnt+1.
  - len_reg=1 gives m_tlast on every beat.
- States:
  - IDLE: cnt==0. Goes to PKT on the first output handshake with m_tlast=0.
  - PKT: cnt!=0. Goes to IDLE on a handshake with m_tlast=1.
  - PAD: present only with the optional feature; see below.
- busy = (state!=IDLE) | (occupancy!=0).
- enable deasserted mid-packet: input stops immediately. Buffered beats still drain and framing continues. Without the optional feature, the packet stays open (busy=1) until enable returns and more data completes it.
- enable toggling never drops or duplicates a beat.
- Counter wrap: cnt never exceeds len_reg-1, so no overflow is possible.

Optional Feature:
- Macro: AXIS_PACKETIZER_PAD_EN.
- Defined:
  - State PAD is entered from PKT when enable=0 and the FIFO is empty.
  - In PAD, m_tvalid=1 and m_tdata=0. Pad beats are counted normally, so the last pad beat carries m_tlast=1, then the block returns to IDLE.
  - If enable returns during PAD, padding still completes first, then FIFO data resumes as a new packet.
  - Result: the DMA always receives whole packets.
- Not defined: PAD state and its logic are absent; a partial packet stays open (see Behaviour).

Test Plan:
- Reset, then enable=1, packet_len=4, 8 input beats 0x1..0x8, m_tready=1 → output 0x1..0x8 in order; m_tlast=1 on 0x4 and 0x8 only; first m_tvalid one cycle after the first input handshake.
- m_tready=0, 20 input beats offered → exactly 16 accepted, then s_tready=0. Set m_tready=1 → all 20 emerge in order; s_tready re-asserts the cycle after the first pop.
- packet_len=0 → m_tlast on every beat.
- packet_len changed from 4 to 2 after beat 2 of a packet → that packet still ends at beat 4; the next packets are 2 beats long.
- Random m_tready/s_tvalid toggling, packet_len=5, 1000 beats → no loss or duplication; m_tlast every 5th beat; m_tdata stable while stalled.
- Two cases with enable=0 after 2 of 4 beats, FIFO drained:
  - Without AXIS_PACKETIZER_PAD_EN: busy stays 1, m_tvalid=0.
  - With AXIS_PACKETIZER_PAD_EN: two 0x0 beats, the second with m_tlast=1, then busy=0.
- resetn=0 mid-packet with 10 beats buffered → next cycle m_tvalid=0, busy=0; the next packet's tlast count restarts from beat 1.

Source files
------------

// File: rtl/axis_packetizer_if.sv
// AXI4-Stream link bundle used on both sides of axis_packetizer.
// The master drives valid/data/last and the slave drives ready.
// The input side of the packetizer has no framing, so its tlast is ignored.
interface axis_packetizer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;

   modport master (
      output tvalid,
      output tdata,
      output tlast,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tdata,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/axis_packetizer.sv
// axis_packetizer: buffers an unframed 32-bit AXI4-Stream in a small
// first-word-fall-through FIFO and frames it into fixed-length packets by
// raising m.tlast every len_reg beats. The framed stream feeds a DMA S2MM port.
//
// Optional feature: define AXIS_PACKETIZER_PAD_EN to pad an open packet with
// zero beats when enable drops and the FIFO runs dry, so the DMA always sees
// whole packets. Without it, a partial packet stays open until enable returns.
//
// Reset is synchronous and active-low (resetn).
module axis_packetizer #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 enable,
   input  logic [LEN_WIDTH-1:0] packet_len,
   axis_packetizer_if.slave     s,
   axis_packetizer_if.master    m,
   output logic                 busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]     CNT_ZERO = '0;
   localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
   localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
   localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PKT  = 2'd1
`ifdef AXIS_PACKETIZER_PAD_EN
      ,
      ST_PAD  = 2'd2
`endif
   } state_t;

   // ---------------------------------------------------------------------
   // Storage and state registers
   // ---------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;       // total occupancy: head + memory
   logic [DATA_WIDTH-1:0] r_head_data;
   logic                  r_head_valid;
   logic                  r_block;       // 1 = input side may not accept
   state_t                r_state;
   logic [LEN_WIDTH-1:0]  r_cnt;
   logic [LEN_WIDTH-1:0]  r_len;

   // ---------------------------------------------------------------------
   // Combinational nets
   // ---------------------------------------------------------------------
   logic                  w_push;
   logic                  w_pop;
   logic                  w_head_load;
   logic [CNT_W-1:0]      w_mem_cnt;
   logic                  w_mem_empty;
   logic                  w_bypass;
   logic                  w_mem_wr;
   logic                  w_mem_rd;
   logic [CNT_W-1:0]      w_count_nxt;

   logic                  w_pad;
   logic                  w_out_valid;
   logic [DATA_WIDTH-1:0] w_out_data;
   logic                  w_out_last;
   logic                  w_out_hs;
   logic [LEN_WIDTH-1:0]  w_cnt_nxt;
   logic [LEN_WIDTH-1:0]  w_len_nxt;
   state_t                w_state_nxt;

   // Input ready depends only on enable and a registered flag, never on m.tready.
   assign s.tready = enable & ~r_block;
   assign w_push   = s.tvalid & s.tready;

   // FIFO steering: decide where a pushed beat lands and whether the head reloads.
   always_comb begin
      // NOTE: every signal assigned in an always_comb gets a default first so
      // no path leaves it unassigned, which would infer a latch.
      w_head_load = 1'b0;
      w_mem_cnt   = CNT_ZERO;
      w_mem_empty = 1'b1;
      w_bypass    = 1'b0;
      w_mem_wr    = 1'b0;
      w_mem_rd    = 1'b0;
      w_count_nxt = r_count;

      // The head register is free when it is empty or being consumed.
      w_head_load = ~r_head_valid | w_pop;
      w_mem_cnt   = r_count - CNT_W'(r_head_valid);
      w_mem_empty = (w_mem_cnt == CNT_ZERO);
      // With nothing queued behind the head, a push goes straight to the head,
      // which gives the one-cycle input-to-output latency.
      w_bypass    = w_push & w_mem_empty & w_head_load;
      w_mem_wr    = w_push & ~w_bypass;
      w_mem_rd    = w_head_load & ~w_mem_empty;
      w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
   end

   // Framing FSM: output mux, tlast, beat counter, length latch and next state.
   always_comb begin
      w_pad       = 1'b0;
      w_out_valid = 1'b0;
      w_out_data  = '0;
      w_out_last  = 1'b0;
      w_out_hs    = 1'b0;
      w_pop       = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_len;
      w_state_nxt = r_state;

`ifdef AXIS_PACKETIZER_PAD_EN
      w_pad = (r_state == ST_PAD);
`endif

      // Pad beats are zero data; otherwise the FIFO head is presented.
      w_out_valid = w_pad | r_head_valid;
      w_out_data  = w_pad ? '0 : r_head_data;
      w_out_last  = w_out_valid & (r_cnt == (r_len - LEN_ONE));
      w_out_hs    = w_out_valid & m.tready;
      // Pad beats never consume FIFO data.
      w_pop       = w_out_hs & ~w_pad;

      if (w_out_hs) begin
         w_cnt_nxt = w_out_last ? LEN_ZERO : (r_cnt + LEN_ONE);
      end

      // The packet length is only sampled between packets.
      if (r_cnt == LEN_ZERO) begin
         w_len_nxt = (packet_len == LEN_ZERO) ? LEN_ONE : packet_len;
      end

      case (r_state)
         ST_IDLE: begin
            if (w_out_hs & ~w_out_last) begin
               w_state_nxt = ST_PKT;
            end
         end
         ST_PKT: begin
            if (w_out_hs & w_out_last) begin
               w_state_nxt = ST_IDLE;
            end
`ifdef AXIS_PACKETIZER_PAD_EN
            else if (~enable && (r_count == CNT_ZERO)) begin
               // Input stopped and nothing left to send: close the packet with zeros.
               w_state_nxt = ST_PAD;
            end
`endif
         end
`ifdef AXIS_PACKETIZER_PAD_EN
         ST_PAD: begin
            if (w_out_hs & w_out_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FIFO memory array: written only, no reset.
   always_ff @(posedge clk) begin
      // NOTE: the data array is deliberately not reset; occupancy and pointers
      // define which entries are live, and a reset here would only cost flops.
      if (w_mem_wr) begin
         r_mem[r_wr_ptr] <= s.tdata;
      end
   end

   // FIFO pointers, occupancy, full flag and registered head.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!resetn) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= CNT_ZERO;
         r_head_data  <= '0;
         r_head_valid <= 1'b0;
         r_block      <= 1'b1;
      end else begin
         r_count <= w_count_nxt;
         r_block <= (w_count_nxt == CNT_FULL);
         if (w_mem_wr) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_mem_rd) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         if (w_head_load) begin
            if (w_mem_rd) begin
               r_head_data  <= r_mem[r_rd_ptr];
               r_head_valid <= 1'b1;
            end else if (w_bypass) begin
               r_head_data  <= s.tdata;
               r_head_valid <= 1'b1;
            end else begin
               r_head_valid <= 1'b0;
            end
         end
      end
   end

   // Framing state register, beat counter and latched packet length.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_cnt   <= LEN_ZERO;
         r_len   <= LEN_ONE;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_len   <= w_len_nxt;
      end
   end

   assign m.tvalid = w_out_valid;
   assign m.tdata  = w_out_data;
   assign m.tlast  = w_out_last;
   assign busy     = (r_state != ST_IDLE) | (r_count != CNT_ZERO);

endmodule

// File: tb/tb_axis_packetizer.sv
// Self-checking bench for axis_packetizer. A queue-based reference model of
// the stream (beats in = beats out, in order; tlast every N beats) is checked
// on every cycle by one monitor; scenario code adds literal expectations.
module tb_axis_packetizer;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int LW    = 16;

   logic          clk        = 1'b0;
   logic          resetn     = 1'b0;
   logic          enable     = 1'b0;
   logic [LW-1:0] packet_len = LW'(4);
   logic          busy;

   axis_packetizer_if #(.DATA_WIDTH(DW)) s_if ();
   axis_packetizer_if #(.DATA_WIDTH(DW)) m_if ();

   axis_packetizer #(
      .DATA_WIDTH(DW),
      .FIFO_DEPTH(DEPTH),
      .LEN_WIDTH (LW)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .enable    (enable),
      .packet_len(packet_len),
      .s         (s_if),
      .m         (m_if),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Scoreboard state
   int            n_checks = 0;
   int            n_fail   = 0;
   int            src_rate = 100;
   int            snk_rate = 100;
   logic [DW-1:0] src_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] obs_data[$];
   bit            obs_last[$];
   int            n_in  = 0;
   int            n_out = 0;
   int            cyc   = 0;
   int            first_in_cyc  = -1;
   int            first_val_cyc = -1;
   int            beat_idx = 0;
   int            cur_len  = 1;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   bit            rst_state = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] obs_d(input int i);
      if (i < obs_data.size()) return 64'(obs_data[i]);
      return 64'hBAD0_BAD0_BAD0;
   endfunction

   function automatic logic [63:0] obs_l(input int i);
      if (i < obs_last.size()) return 64'(obs_last[i]);
      return 64'd2;
   endfunction

   // Source: offers queued beats, holding valid/data until accepted.
   always begin : src_drv
      bit src_hs;
      @(negedge clk);
      src_hs = s_if.tvalid && s_if.tready && resetn;
      @(posedge clk);
      #1;
      if (src_hs && src_q.size() != 0) void'(src_q.pop_front());
      if (!resetn || src_q.size() == 0) begin
         s_if.tvalid = 1'b0;
      end else if (!s_if.tvalid || src_hs) begin
         s_if.tvalid = ($urandom_range(99) < src_rate);
      end
      s_if.tdata = (src_q.size() != 0) ? src_q[0] : '0;
   end

   // Sink: random back-pressure.
   always begin : snk_drv
      @(posedge clk);
      #1;
      m_if.tready = ($urandom_range(99) < snk_rate);
   end

   // Monitor and reference model, sampled on the falling edge.
   always @(negedge clk) begin : mon
      logic [DW-1:0] exp_d;
      bit            exp_last;
      int            occ;
      cyc++;
      if (!resetn) begin
         exp_q.delete();
         beat_idx   = 0;
         prev_stall = 1'b0;
         rst_state  = 1'b1;
      end else if (rst_state) begin
         check("rst_s_tready", s_if.tready, 0);
         check("rst_m_tvalid", m_if.tvalid, 0);
         check("rst_m_tlast",  m_if.tlast, 0);
         check("rst_m_tdata",  m_if.tdata, 0);
         check("rst_busy",     busy, 0);
         rst_state = 1'b0;
      end else begin
         occ = exp_q.size();
         check("s_tready", s_if.tready, (enable && occ != DEPTH));
         check("busy", busy, (occ != 0) || (beat_idx != 0));
`ifndef AXIS_PACKETIZER_PAD_EN
         check("m_tvalid", m_if.tvalid, (occ != 0));
`endif
         if (prev_stall) begin
            check("stall_valid", m_if.tvalid, 1);
            check("stall_data",  m_if.tdata, prev_data);
            check("stall_last",  m_if.tlast, prev_last);
         end
         if (m_if.tvalid && m_if.tready) begin
            exp_d = (occ != 0) ? exp_q.pop_front() : '0;
            if (beat_idx == 0) cur_len = (packet_len == 0) ? 1 : int'(packet_len);
            exp_last = (beat_idx == cur_len - 1);
            check("m_tdata", m_if.tdata, exp_d);
            check("m_tlast", m_if.tlast, exp_last);
            beat_idx = exp_last ? 0 : beat_idx + 1;
            obs_data.push_back(m_if.tdata);
            obs_last.push_back(m_if.tlast);
            n_out++;
         end
         prev_stall = m_if.tvalid && !m_if.tready;
         prev_data  = m_if.tdata;
         prev_last  = m_if.tlast;
         if (s_if.tvalid && s_if.tready) begin
            exp_q.push_back(s_if.tdata);
            n_in++;
            if (first_in_cyc < 0) first_in_cyc = cyc;
         end
         if (m_if.tvalid && first_val_cyc < 0) first_val_cyc = cyc;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_log();
      obs_data.delete();
      obs_last.delete();
      n_in  = 0;
      n_out = 0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((src_q.size() != 0 || exp_q.size() != 0 || busy || s_if.tvalid) && n < budget);
      check(name, (n < budget), 1);
      cycles(1);
   endtask

   task automatic wait_src_empty(input string name, input int budget);
      int n = 0;
      while ((src_q.size() != 0 || s_if.tvalid) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, (n < budget), 1);
   endtask

   initial begin : watchdog
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin : main
      int  cnt;
      bit  found;
      s_if.tlast = 1'b0;
      resetn = 1'b0;
      enable = 1'b0;
      cycles(3);
      resetn = 1'b1;
      cycles(2);

      // T1: packet_len=4, 8 beats, free-flowing
      packet_len = LW'(4);
      enable     = 1'b1;
      cycles(3);
      clear_log();
      first_in_cyc  = -1;
      first_val_cyc = -1;
      for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
      wait_idle("t1_drain", 200);
      check("t1_count", obs_data.size(), 8);
      for (int i = 0; i < 8; i++) begin
         check("t1_data", obs_d(i), i + 1);
         check("t1_last", obs_l(i), (i == 3 || i == 7));
      end
      check("t1_latency", first_val_cyc - first_in_cyc, 1);

      // T2: fill with sink stalled, then release
      snk_rate = 0;
      cycles(2);
      clear_log();
      for (int i = 0; i < 20; i++) src_q.push_back(DW'(32'h100 + i));
      cycles(40);
      check("t2_accepted", n_in, 16);
      check("t2_full_ready", s_if.tready, 0);
      snk_rate = 100;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (m_if.tvalid && m_if.tready) found = 1'b1;
      end
      check("t2_pop_seen", found, 1);
      check("t2_ready_at_pop", s_if.tready, 0);
      @(negedge clk);
      check("t2_ready_after_pop", s_if.tready, 1);
      wait_idle("t2_drain", 400);
      check("t2_out", n_out, 20);
      for (int i = 0; i < 20; i++) check("t2_order", obs_d(i), 32'h100 + i);

      // T3: packet_len=0 means one-beat packets
      packet_len = LW'(0);
      cycles(3);
      clear_log();
      src_rate = 60;
      snk_rate = 70;
      for (int i = 0; i < 6; i++) src_q.push_back(DW'(32'h200 + i));
      wait_idle("t3_drain", 400);
      check("t3_count", obs_data.size(), 6);
      for (int i = 0; i < 6; i++) check("t3_last", obs_l(i), 1);

      // T4: length change mid-packet only affects following packets
      src_rate   = 100;
      snk_rate   = 100;
      packet_len = LW'(4);
      cycles(3);
      clear_log();
      for (int i = 0; i < 8; i++) src_q.push_back(DW'(32'h40 + i));
      cnt = 0;
      for (int k = 0; k < 50 && cnt < 2; k++) begin
         @(negedge clk);
         if (m_if.tvalid && m_if.tready) cnt++;
      end
      check("t4_two_beats", cnt, 2);
      @(posedge clk);
      #2;
      packet_len = LW'(2);
      wait_idle("t4_drain", 200);
      check("t4_count", obs_data.size(), 8);
      for (int i = 0; i < 8; i++) check("t4_last", obs_l(i), (i == 3 || i == 5 || i == 7));

      // T5: random traffic, packet_len=5, 1000 beats
      packet_len = LW'(5);
      cycles(3);
      clear_log();
      src_rate = 70;
      snk_rate = 60;
      for (int i = 0; i < 1000; i++) src_q.push_back(DW'($urandom()));
      wait_idle("t5_drain", 20000);
      check("t5_out", n_out, 1000);
      cnt = 0;
      for (int i = 0; i < obs_last.size(); i++) cnt += int'(obs_last[i]);
      check("t5_packets", cnt, 200);

      // T6: enable dropped after 2 of 4 beats
      src_rate   = 100;
      snk_rate   = 100;
      packet_len = LW'(4);
      cycles(3);
      clear_log();
      src_q.push_back(DW'(32'h61));
      src_q.push_back(DW'(32'h62));
      wait_src_empty("t6_accept", 50);
      enable = 1'b0;
      cycles(10);
`ifdef AXIS_PACKETIZER_PAD_EN
      check("t6_pad_count", obs_data.size(), 4);
      check("t6_pad_d2", obs_d(2), 0);
      check("t6_pad_d3", obs_d(3), 0);
      check("t6_pad_l2", obs_l(2), 0);
      check("t6_pad_l3", obs_l(3), 1);
      check("t6_pad_busy", busy, 0);
      enable = 1'b1;
      cycles(2);
`else
      check("t6_busy_open", busy, 1);
      check("t6_no_valid", m_if.tvalid, 0);
      check("t6_count", obs_data.size(), 2);
      enable = 1'b1;
      src_q.push_back(DW'(32'h63));
      src_q.push_back(DW'(32'h64));
      wait_idle("t6_drain", 200);
      check("t6_total", obs_data.size(), 4);
      check("t6_l1", obs_l(1), 0);
      check("t6_l3", obs_l(3), 1);
      check("t6_d3", obs_d(3), 32'h64);
`endif

      // T7: reset mid-packet with 10 beats buffered
      snk_rate = 0;
      cycles(2);
      clear_log();
      for (int i = 0; i < 10; i++) src_q.push_back(DW'(32'h80 + i));
      wait_src_empty("t7_fill", 100);
      cycles(1);
      resetn = 1'b0;
      src_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("t7_rst_valid", m_if.tvalid, 0);
      check("t7_rst_busy", busy, 0);
      @(posedge clk);
      #2;
      resetn   = 1'b1;
      snk_rate = 100;
      cycles(2);
      clear_log();
      for (int i = 0; i < 4; i++) src_q.push_back(DW'(32'hA1 + i));
      wait_idle("t7_drain", 200);
      check("t7_count", obs_data.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("t7_data", obs_d(i), 32'hA1 + i);
         check("t7_last", obs_l(i), (i == 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
